ifetch_unit: RTL and testbench

//  Instruction fetch front-end feeding the QUAD.nibble cpu core. Holds the fetch PC and

---
 rtl/ifetch_unit_pkg.sv | 9 +
 rtl/ifetch_unit_if.sv | 27 ++
 rtl/ifetch_unit_queue.sv | 50 +++++
 rtl/ifetch_unit.sv | 102 ++++++++++
 tb/tb_ifetch_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-side types and constants for the QUAD.nibble core.
package ifetch_unit_pkg;
    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;

    localparam addr_t RESET_PC = 16'h0400;

    typedef enum logic {FETCH, FLUSH} fetch_state_e;
endpackage

// File: rtl/ifetch_unit_if.sv
// Program-memory, redirect and instruction-delivery signals of the fetch unit.
interface ifetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/ifetch_unit_queue.sv
// Prefetch FIFO holding {word, pc} pairs; head is read straight from registered storage.
module ifetch_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic                    push_ok, pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// Fetch front-end: fetch PC, read credits, stale-response dropping and prefetch queue.
module ifetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ifetch_unit_pkg::RESET_PC
) (
    input logic           clk,
    input logic           resetn,
    ifetch_unit_if.master bus
);
    import ifetch_unit_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

    fetch_state_e              state_q, state_d;
    logic [ADDR_W-1:0]         fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]             outst_q, outst_d, drop_q, drop_d, count;
    logic                      push, pop, flush, full, empty, rv_ok, issue, credit;
    logic [DATA_W+ADDR_W-1:0]  head, hold_q;

    // A same-cycle pop frees its slot so ready held high sustains one word per cycle.
    assign pop    = bus.instr_valid & bus.instr_ready;
    assign credit = ({1'b0, count} + {1'b0, outst_q} - {{CW{1'b0}}, pop}) < DEPTH_X;
    assign bus.imem_req  = resetn & (state_q == FETCH) & ~bus.redirect_valid & credit;
    assign bus.imem_addr = fetch_pc_q;
    assign issue = bus.imem_req & bus.imem_gnt;
    assign rv_ok = bus.imem_rvalid & ((state_q == FETCH) ? (outst_q != '0) : (drop_q != '0));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (bus.redirect_valid) begin
            flush      = 1'b1;
            fetch_pc_d = bus.redirect_pc;
            rsp_pc_d   = bus.redirect_pc;
            outst_d    = '0;
            drop_d     = ((state_q == FETCH) ? outst_q : drop_q) - CW'(rv_ok);
            state_d    = (drop_d == '0) ? FETCH : FLUSH;
        end else begin
            case (state_q)
                FETCH: begin
                    push    = rv_ok;
                    outst_d = outst_q + CW'(issue) - CW'(rv_ok);
                    if (issue) fetch_pc_d = fetch_pc_q + 1'b1;
                    if (rv_ok) rsp_pc_d   = rsp_pc_q + 1'b1;
                end
                FLUSH: begin
                    if (rv_ok) begin
                        drop_d = drop_q - 1'b1;
                        if (drop_q == CW'(1)) state_d = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            if (!empty) hold_q <= head;
        end
    end

    ifetch_queue #(.W(DATA_W + ADDR_W), .DEPTH(DEPTH), .CW(CW)) u_queue (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    ({bus.imem_rdata, rsp_pc_q}),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // An empty queue keeps showing the last head rather than stale storage.
    assign bus.instr_valid = ~empty;
    assign {bus.instr_data, bus.instr_pc} = empty ? hold_q : head;

    a_rv_orphan: assert property (@(posedge clk) disable iff (!resetn)
        !(bus.imem_rvalid && state_q == FETCH && outst_q == '0));
    a_push_full: assert property (@(posedge clk) disable iff (!resetn) !(push && full));
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a queue-based memory and stream model.
module tb_ifetch_unit;
    localparam int DEPTH = 2;
    localparam logic [15:0] RST_PC = 16'h0400;

    typedef struct { logic [15:0] a; int rdy; } pend_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    ifetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus();

    ifetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    pend_t       pend[$];
    logic [15:0] hs_pcs[$];
    int          total, bad, cyc, flush_left, live, drops, hs_cnt, iss_cnt;
    int          gnt_pct, lat_min, lat_max;
    logic [15:0] exp_pc, nxt_pc, first_pc, prev_addr;
    logic        got_first, prev_stall;
    logic        o_req, o_valid, o_hs, o_rv;
    logic [15:0] o_pc, o_data, o_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at negedge, observe, then advance the model for the coming edge.
    task automatic step(input logic rst, input logic rdy, input logic redir, input logic [15:0] rpc);
        pend_t p;
        logic  rv, gnt, req, hs;
        @(negedge clk);
        cyc++;
        resetn = ~rst;
        gnt = ($urandom_range(99) < gnt_pct);
        rv  = !rst && pend.size() > 0 && pend[0].rdy <= cyc;
        bus.imem_gnt       = gnt;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rv ? (pend[0].a ^ 16'hA5A5) : 16'($urandom);
        bus.instr_ready    = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
        req = bus.imem_req;
        o_req = req; o_valid = bus.instr_valid; o_pc = bus.instr_pc;
        o_data = bus.instr_data; o_addr = bus.imem_addr; o_rv = rv; o_hs = 1'b0;
        if (rst) begin
            chk("rst_req", req, 0);
            pend.delete(); hs_pcs.delete();
            exp_pc = RST_PC; nxt_pc = RST_PC;
            flush_left = 0; live = 0; prev_stall = 0; got_first = 0;
            return;
        end
        hs = bus.instr_valid && rdy;
        o_hs = hs;
        if (hs) begin
            chk("hs_pc", bus.instr_pc, exp_pc);
            chk("hs_data", bus.instr_data, exp_pc ^ 16'hA5A5);
            hs_pcs.push_back(bus.instr_pc);
            if (!got_first) begin first_pc = bus.instr_pc; got_first = 1; end
            exp_pc++; live--; hs_cnt++;
        end
        if (req) begin
            chk("credit", ((pend.size() - flush_left + live) < DEPTH), 1);
            chk("req_in_flush", flush_left, 0);
            chk("req_on_redirect", redir, 0);
            chk("iss_addr", bus.imem_addr, nxt_pc);
            if (prev_stall) chk("addr_hold", bus.imem_addr, prev_addr);
        end
        prev_stall = req && !gnt;
        prev_addr  = bus.imem_addr;
        if (rv) begin
            p = pend.pop_front();
            if (flush_left > 0) begin flush_left--; drops++; end
            else live++;
        end
        if (req && gnt) begin
            pend.push_back('{nxt_pc, cyc + int'($urandom_range(lat_max, lat_min))});
            nxt_pc++; iss_cnt++;
        end
        if (redir) begin
            exp_pc = rpc; nxt_pc = rpc;
            flush_left = pend.size(); live = 0;
            got_first = 0; prev_stall = 0; hs_pcs.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic rst, rdy, redir;
        logic [15:0] rpc;
        total = 0; bad = 0; cyc = 0; drops = 0; hs_cnt = 0; iss_cnt = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        resetn = 1'b0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;

        // 1: reset values, fill latency, streaming throughput
        repeat (2) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("t1_rst_valid", o_valid, 0);
        chk("t1_rst_pc", o_pc, 0);
        chk("t1_rst_data", o_data, 0);
        chk("t1_req", o_req, 1);
        chk("t1_addr", o_addr, 16'h0400);
        step(0, 1, 0, 0);
        chk("t1_valid_early", o_valid, 0);
        step(0, 1, 0, 0);
        chk("t1_valid", o_valid, 1);
        chk("t1_first_pc", o_pc, 16'h0400);
        hs_cnt = 0;
        repeat (12) step(0, 1, 0, 0);
        chk("t1_thru", hs_cnt, 12);

        // 2: stalled consumer
        step(1, 0, 0, 0);
        iss_cnt = 0;
        repeat (10) step(0, 0, 0, 0);
        chk("t2_issued", iss_cnt, DEPTH);
        chk("t2_req_low", o_req, 0);
        step(0, 1, 0, 0);
        chk("t2_hs0", o_hs, 1);
        chk("t2_pc0", o_pc, 16'h0400);
        step(0, 1, 0, 0);
        chk("t2_hs1", o_hs, 1);
        chk("t2_pc1", o_pc, 16'h0401);

        // 3: redirect with two slow reads in flight
        step(1, 0, 0, 0);
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 10 && pend.size() < 2; i++) step(0, 0, 0, 0);
        chk("t3_pend", pend.size(), 2);
        drops = 0;
        step(0, 0, 1, 16'h1000);
        chk("t3_stale", flush_left, 2);
        repeat (12) step(0, 1, 0, 0);
        chk("t3_drops", drops, 2);
        chk("t3_got", got_first, 1);
        chk("t3_pc", first_pc, 16'h1000);
        lat_min = 1; lat_max = 1;

        // 4: redirect from idle-full to the top of the address space
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 1, 16'hFFFE);
        step(0, 1, 0, 0);
        chk("t4_req", o_req, 1);
        chk("t4_addr", o_addr, 16'hFFFE);
        step(0, 1, 0, 0);
        chk("t4_valid_early", o_valid, 0);
        step(0, 1, 0, 0);
        chk("t4_valid", o_valid, 1);
        repeat (2) step(0, 1, 0, 0);
        chk("t4_n", hs_pcs.size() >= 3, 1);
        chk("t4_pc0", hs_pcs[0], 16'hFFFE);
        chk("t4_pc1", hs_pcs[1], 16'hFFFF);
        chk("t4_pc2", hs_pcs[2], 16'h0000);

        // 5: redirect coinciding with a handshake and a response
        repeat (6) step(0, 1, 0, 0);
        step(0, 1, 1, 16'h2000);
        chk("t5_hs", o_hs, 1);
        chk("t5_rv", o_rv, 1);
        repeat (6) step(0, 1, 0, 0);
        chk("t5_got", got_first, 1);
        chk("t5_pc", first_pc, 16'h2000);

        // 6: random traffic with a one-cycle reset mid-stream
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            rst   = (i == 700);
            rdy   = (i > 700 && i <= 760) ? 1'b1 : 1'($urandom_range(1));
            redir = !rst && !(i > 700 && i <= 760) && ($urandom_range(99) < 3);
            rpc   = ($urandom_range(3) == 0) ? 16'hFFFD + 16'($urandom_range(2)) : 16'($urandom);
            step(rst, rdy, redir, rpc);
            if (i == 701) begin
                chk("t6_rst_valid", o_valid, 0);
                chk("t6_rst_pc", o_pc, 0);
                chk("t6_rst_data", o_data, 0);
            end
            if (i == 760) begin
                chk("t6_got", got_first, 1);
                chk("t6_pc", first_pc, 16'h0400);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
